// File: rtl/gabor_frame_sequencer.sv
// Frame-level flow controller metering raster pixels into the 4-line-buffer Gabor image controller.
// Lines are released against buffer credits returned by the controller's per-line read-done interrupt.
module gabor_frame_sequencer #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512,
    parameter int unsigned NUM_LBUF   = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_intr,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [9:0]        o_lines_sent,
    output logic [9:0]        o_intr_count,
    output logic              o_err
);
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned CRED_W = $clog2(NUM_LBUF + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, DRAIN, DONE} state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [CRED_W-1:0]  credit;
    logic [CRED_W-1:0]  credit_n;
    logic [CNT_W-1:0]   lines_n;
    logic [CNT_W-1:0]   intr_n;
    logic               xfer;
    logic               line_end;
    logic               intr_act;
    logic               intr_sat;

    // Next-value arithmetic shared by the state register below.
    always_comb begin
        xfer     = s_valid && s_ready;
        line_end = xfer && (col == COL_W'(IMG_WIDTH - 1));
        intr_act = i_intr && (state != IDLE);
        // A line end in the same cycle consumes the returned credit, so it can never saturate.
        intr_sat = intr_act && !line_end && (credit == CRED_W'(NUM_LBUF));
        credit_n = credit;
        if (line_end && !intr_act) begin
            credit_n = credit - CRED_W'(1);
        end else if (intr_act && !line_end && !intr_sat) begin
            credit_n = credit + CRED_W'(1);
        end
        lines_n = o_lines_sent;
        if (line_end) begin
            lines_n = o_lines_sent + CNT_W'(1);
        end
        intr_n = o_intr_count;
        if (intr_act) begin
            intr_n = o_intr_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            o_pix_valid  <= 1'b0;
            o_pix_data   <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_lines_sent <= '0;
            o_intr_count <= '0;
            credit       <= CRED_W'(NUM_LBUF);
            col          <= '0;
            o_err        <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_pix_valid  <= xfer;
            if (xfer) begin
                o_pix_data <= s_data;
                col        <= line_end ? '0 : col + COL_W'(1);
            end
            if (state != IDLE) begin
                credit       <= credit_n;
                o_lines_sent <= lines_n;
                o_intr_count <= intr_n;
            end
            if (i_intr && (state == IDLE || intr_sat)) begin
                o_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    s_ready <= 1'b0;
                    if (i_start) begin
                        state        <= SEND;
                        s_ready      <= 1'b1;
                        o_busy       <= 1'b1;
                        o_lines_sent <= '0;
                        o_intr_count <= '0;
                        credit       <= CRED_W'(NUM_LBUF);
                        col          <= '0;
                        o_err        <= 1'b0;
                    end
                end
                SEND: begin
                    if (line_end && lines_n == CNT_W'(IMG_HEIGHT)) begin
                        state   <= DRAIN;
                        s_ready <= 1'b0;
                    end else if (credit_n == '0) begin
                        state   <= WAIT;
                        s_ready <= 1'b0;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (credit_n != '0) begin
                        state   <= SEND;
                        s_ready <= 1'b1;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    s_ready <= 1'b0;
                    if (intr_n >= CNT_W'(IMG_HEIGHT - 2)) begin
                        state        <= DONE;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gabor_frame_sequencer.sv
// Directed bench for gabor_frame_sequencer on a reduced 8x8 frame.
// Driven pixels go into a scoreboard queue and are popped as the DUT presents them.
module tb_gabor_frame_sequencer;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int LB = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          intr = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [9:0]    lines;
    logic [9:0]    icnt;
    logic          err;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] sb[$];
    bit            exp_v = 1'b0;
    bit            last_xfer = 1'b0;
    int            pix_cnt = 0;
    int            src = 0;
    int            nd;

    always #5 clk = ~clk;

    gabor_frame_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LBUF(LB), .DATA_W(DW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_pix_data(pix_data), .o_pix_valid(pix_valid), .i_intr(intr),
        .o_busy(busy), .o_frame_done(frame_done),
        .o_lines_sent(lines), .o_intr_count(icnt), .o_err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record each handshake at the edge; its pixel must appear exactly one cycle later.
    always @(posedge clk) begin
        last_xfer = s_valid && s_ready && !rst;
        exp_v     = last_xfer;
        if (last_xfer) sb.push_back(s_data);
    end

    always @(negedge clk) begin
        check("pix_valid_timing", {31'b0, pix_valid}, {31'b0, exp_v});
        if (pix_valid === 1'b1) begin
            pix_cnt++;
            if (sb.size() > 0) check("pix_data", {24'b0, pix_data}, {24'b0, sb.pop_front()});
        end
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; intr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Continuous valid source with no interrupts for n cycles.
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            if (last_xfer) src++;
            s_data  = DW'(src);
            s_valid = 1'b1;
            @(negedge clk);
        end
        if (last_xfer) src++;
        s_valid = 1'b0;
    endtask

    // Drive one frame; intr is returned dly cycles after each line end from line 3 on.
    task automatic run_frame(input int vpct, input int dly, input bit coincide,
                             input int abort_at, output int ndone);
        int cyc = 0;
        int sent = 0;
        int tail = 0;
        int due[$];
        ndone   = 0;
        pix_cnt = 0;
        s_valid = 1'b0;
        pulse_start();
        check("busy_after_start", {31'b0, busy}, 32'd1);
        while (cyc < 4000 && tail < 6) begin
            if (last_xfer) begin
                sent++;
                src++;
                if (sent % W == 0) begin
                    if (coincide && sent / W == 4) check("coincide_ready", {31'b0, s_ready}, 32'd1);
                    if (sent / W >= 3 && !(coincide && sent / W == 3)) due.push_back(cyc + dly);
                end
            end
            if (abort_at > 0 && sent == abort_at) begin
                rst = 1'b1; s_valid = 1'b0; intr = 1'b0;
                return;
            end
            if (frame_done === 1'b1) ndone++;
            if (ndone > 0) tail++;
            s_valid = ($urandom_range(99) < vpct);
            s_data  = DW'(src);
            intr    = 1'b0;
            if (due.size() > 0 && due[0] <= cyc) begin
                intr = 1'b1;
                void'(due.pop_front());
            end
            if (coincide && sent == 4 * W - 1 && s_ready === 1'b1) begin
                s_valid = 1'b1;
                intr    = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        intr    = 1'b0;
    endtask

    task automatic frame_checks(input int ndone);
        check("frame_done_count", ndone, 32'd1);
        check("frame_pixels", pix_cnt, W * H);
        check("frame_lines", {22'b0, lines}, H);
        check("frame_intr", {22'b0, icnt}, H - 2);
        check("frame_busy_low", {31'b0, busy}, 32'd0);
        check("frame_err", {31'b0, err}, 32'd0);
        check("frame_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_lines", {22'b0, lines}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        // Credits alone allow exactly four lines.
        pix_cnt = 0;
        pulse_start();
        stream(60);
        check("t1_pixels", pix_cnt, LB * W);
        check("t1_s_ready", {31'b0, s_ready}, 32'd0);
        check("t1_lines", {22'b0, lines}, LB);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_intr", {22'b0, icnt}, 32'd0);

        do_reset();
        run_frame(100, 20, 1'b0, 0, nd);
        frame_checks(nd);

        do_reset();
        run_frame(100, 20, 1'b1, 0, nd);
        frame_checks(nd);

        run_frame(50, 3, 1'b0, 0, nd);
        frame_checks(nd);

        // Interrupt with full credit flags an error without adding a fifth credit.
        do_reset();
        pulse_start();
        intr = 1'b1;
        @(negedge clk);
        intr = 1'b0;
        check("t5_err_set", {31'b0, err}, 32'd1);
        pix_cnt = 0;
        stream(60);
        check("t5_pixels", pix_cnt, LB * W);
        check("t5_s_ready", {31'b0, s_ready}, 32'd0);
        check("t5_err_sticky", {31'b0, err}, 32'd1);
        pulse_start();
        check("t5_start_ignored_busy", {31'b0, busy}, 32'd1);
        check("t5_start_ignored_lines", {22'b0, lines}, LB);
        do_reset();
        intr = 1'b1;
        @(negedge clk);
        intr = 1'b0;
        check("t5_err_idle", {31'b0, err}, 32'd1);
        pulse_start();
        check("t5_err_cleared", {31'b0, err}, 32'd0);

        // Reset in the middle of line 7, then a clean frame.
        do_reset();
        run_frame(100, 12, 1'b0, 6 * W + 4, nd);
        @(negedge clk);
        check("t6_s_ready", {31'b0, s_ready}, 32'd0);
        check("t6_pix_valid", {31'b0, pix_valid}, 32'd0);
        check("t6_pix_data", {24'b0, pix_data}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_frame_done", {31'b0, frame_done}, 32'd0);
        check("t6_lines", {22'b0, lines}, 32'd0);
        check("t6_intr", {22'b0, icnt}, 32'd0);
        check("t6_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(100, 12, 1'b0, 0, nd);
        frame_checks(nd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
